touch_scan_sequencer: RTL

//  Schedules periodic Z/X/Y conversions on the shared touchpad SPI conversion engine via a req/done handshake.

---
 rtl/touch_scan_sequencer_if.sv | 22 ++
 rtl/touch_scan_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/touch_scan_sequencer_if.sv
// Handshake bundle between the scan sequencer and the SPI conversion engine.
// master = sequencer side, slave = conversion engine side.
interface touch_scan_sequencer_if;
  logic        conv_req;
  logic [1:0]  conv_chan;
  logic        conv_done;
  logic [11:0] conv_data;

  modport master (
    output conv_req,
    output conv_chan,
    input  conv_done,
    input  conv_data
  );

  modport slave (
    input  conv_req,
    input  conv_chan,
    output conv_done,
    output conv_data
  );
endinterface

// File: rtl/touch_scan_sequencer.sv
// Periodic Z/X/Y touch scan with pen-down gating and calibration.
// Optional: define TOUCH_AVG_EN to average 4 samples per X/Y axis.
module touch_scan_sequencer #(
  parameter int          SCAN_PERIOD = 100000,
  parameter int          TIMEOUT     = 4096,
  parameter logic [11:0] Z_THRESH    = 12'h200,
  parameter logic [11:0] X_MIN       = 12'h096,
  parameter logic [11:0] X_MAX       = 12'hF6E,
  parameter logic [11:0] Y_MIN       = 12'h12C,
  parameter logic [11:0] Y_MAX       = 12'hED8
) (
  input  logic                   cclk,
  input  logic                   rstb,
  input  logic                   scan_en,
  touch_scan_sequencer_if.master bus,
  output logic [8:0]             x,
  output logic [8:0]             y,
  output logic                   pen_down,
  output logic                   touch_valid,
  output logic                   scan_overrun,
  output logic                   conv_timeout
);

  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CH_X = 2'b00;
  localparam logic [1:0] CH_Y = 2'b01;
  localparam logic [1:0] CH_Z = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE
  } state_t;

  state_t      state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic        req_q;
  logic [1:0]  chan_q;
  logic [11:0] x_raw;
  logic        tick;

`ifdef TOUCH_AVG_EN
  logic [13:0] acc;
  logic [1:0]  scnt;
`endif

  assign tick          = (pcnt == PW'(SCAN_PERIOD - 1));
  assign bus.conv_req  = req_q;
  assign bus.conv_chan = chan_q;

  // Saturating offset removal, ceiling clamp, then drop 3 LSBs.
  function automatic logic [8:0] cal(
    input logic [11:0] raw,
    input logic [11:0] mn,
    input logic [11:0] mx
  );
    logic [11:0] adj;
    adj = (raw < mn) ? 12'd0 : raw - mn;
    if (adj > mx)
      adj = mx;
    return adj[11:3];
  endfunction

`ifdef TOUCH_AVG_EN
  function automatic logic [11:0] avg4(
    input logic [13:0] a,
    input logic [11:0] d
  );
    logic [13:0] s;
    s = a + {2'b00, d};
    return s[13:2];
  endfunction

  function automatic logic [13:0] accum(
    input logic [13:0] a,
    input logic [11:0] d
  );
    return a + {2'b00, d};
  endfunction
`endif

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state        <= IDLE;
      pcnt         <= '0;
      tcnt         <= '0;
      req_q        <= 1'b0;
      chan_q       <= CH_Z;
      x_raw        <= '0;
      x            <= '0;
      y            <= '0;
      pen_down     <= 1'b0;
      touch_valid  <= 1'b0;
      scan_overrun <= 1'b0;
      conv_timeout <= 1'b0;
`ifdef TOUCH_AVG_EN
      acc          <= '0;
      scnt         <= '0;
`endif
    end else begin
      touch_valid  <= 1'b0;
      scan_overrun <= 1'b0;
      conv_timeout <= 1'b0;
      pcnt         <= tick ? '0 : pcnt + 1'b1;

      // A tick during an active scan is dropped, not queued.
      if (tick && state != IDLE)
        scan_overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (tick && scan_en) begin
            state  <= ISSUE;
            chan_q <= CH_Z;
`ifdef TOUCH_AVG_EN
            acc    <= '0;
            scnt   <= '0;
`endif
          end
        end

        ISSUE: begin
          req_q <= 1'b1;
          tcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (bus.conv_done) begin
            req_q <= 1'b0;
            unique case (1'b1)
              (chan_q == CH_Z): begin
                if (bus.conv_data < Z_THRESH) begin
                  pen_down <= 1'b0;
                  state    <= IDLE;
                end else begin
                  pen_down <= 1'b1;
                  chan_q   <= CH_X;
                  state    <= ISSUE;
                end
              end
              (chan_q == CH_X): begin
                state <= ISSUE;
`ifdef TOUCH_AVG_EN
                acc   <= accum(acc, bus.conv_data);
                scnt  <= scnt + 2'd1;
                if (scnt == 2'd3) begin
                  x_raw  <= avg4(acc, bus.conv_data);
                  acc    <= '0;
                  chan_q <= CH_Y;
                end
`else
                x_raw  <= bus.conv_data;
                chan_q <= CH_Y;
`endif
              end
              (chan_q == CH_Y): begin
`ifdef TOUCH_AVG_EN
                scnt <= scnt + 2'd1;
                if (scnt == 2'd3) begin
                  x           <= cal(x_raw, X_MIN, X_MAX);
                  y           <= cal(avg4(acc, bus.conv_data),
                                     Y_MIN, Y_MAX);
                  touch_valid <= 1'b1;
                  state       <= UPDATE;
                end else begin
                  acc   <= accum(acc, bus.conv_data);
                  state <= ISSUE;
                end
`else
                x           <= cal(x_raw, X_MIN, X_MAX);
                y           <= cal(bus.conv_data, Y_MIN, Y_MAX);
                touch_valid <= 1'b1;
                state       <= UPDATE;
`endif
              end
              default: state <= IDLE;
            endcase
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            req_q        <= 1'b0;
            conv_timeout <= 1'b1;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        UPDATE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
